// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressed data memory with lane strobes, scrub engine, range/alignment flags
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_memory_sized #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int TEST_ADDR  = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic                    WE,
  input  logic [1:0]              SIZE,
  input  logic                    UNS,
  input  logic [DATA_WIDTH-1:0]   WD,
  input  logic                    CLR,
  output logic [DATA_WIDTH-1:0]   RD,
  output logic                    BUSY,
  output logic                    OOR,
  output logic                    MISALIGN,
  output logic                    ERR_STICKY,
  output logic [DATA_WIDTH/2-1:0] test_value
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int NH  = DATA_WIDTH / 16;
  localparam int OFS = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - OFS;
  localparam int PW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {S_IDLE, S_SCRUB} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IW-1:0]         word_idx;
  logic [OFS-1:0]        lane;
  logic [OFS-2:0]        hlane;
  logic [PW-1:0]         idx;
  logic [PW-1:0]         rd_idx;
  logic                  oor;
  logic                  mis;
  logic                  busy;
  logic                  is_byte;
  logic                  is_half;
  logic [DATA_WIDTH-1:0] word_rd;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [DATA_WIDTH-1:0] tv_word;
  logic [DATA_WIDTH-1:0] rd_v;
  logic [DATA_WIDTH-1:0] st_data;
  logic [NB-1:0]         st_be;
  logic                  wr_en;
  logic [PW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;

  assign word_idx = A[ADDR_WIDTH-1:OFS];
  assign lane     = A[OFS-1:0];
  assign hlane    = A[OFS-1:1];
  assign idx      = word_idx[PW-1:0];
  assign oor      = (word_idx >= IW'(MEM_DEPTH));
  assign rd_idx   = oor ? '0 : idx;
  assign is_byte  = (SIZE == 2'b00);
  assign is_half  = (SIZE == 2'b01);
  assign busy     = (state_q == S_SCRUB);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (is_half && A[0]) || (!is_byte && !is_half && (lane != '0));
`else
  // Lane selection below already ignores the sub-natural address bits.
  assign mis = 1'b0;
`endif

  assign word_rd    = mem[rd_idx];
  assign byte_shift = word_rd >> {lane, 3'b000};
  assign half_shift = word_rd >> {hlane, 4'b0000};
  assign tv_word    = mem[TEST_ADDR];

  always_comb begin
    rd_v = word_rd;
    if (is_byte) begin
      rd_v = {{(DATA_WIDTH-8){~UNS & byte_shift[7]}}, byte_shift[7:0]};
    end else if (is_half) begin
      rd_v = {{(DATA_WIDTH-16){~UNS & half_shift[15]}}, half_shift[15:0]};
    end
    if (busy || oor || mis) begin
      rd_v = '0;
    end
  end

  always_comb begin
    st_data = WD;
    st_be   = '1;
    if (is_byte) begin
      st_data = {NB{WD[7:0]}};
      st_be   = NB'(1) << lane;
    end else if (is_half) begin
      st_data = {NH{WD[15:0]}};
      st_be   = NB'(3) << {hlane, 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = st_data;
    wr_be   = st_be;
    case (state_q)
      S_SCRUB: begin
        wr_en   = 1'b1;
        wr_data = '0;
        wr_be   = '1;
        ptr_d   = ptr_q + PW'(1);
        if (ptr_q == PW'(MEM_DEPTH-1)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        if (WE && !oor && !mis) begin
          wr_en  = 1'b1;
          wr_idx = idx;
        end
        if (WE && (oor || mis)) begin
          err_d = 1'b1;
        end
        if (CLR) begin
          state_d = S_SCRUB;
          ptr_d   = '0;
        end
      end
    endcase
    // A clear request always wins over a same-cycle error.
    if (CLR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_SCRUB;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign RD         = rd_v;
  assign BUSY       = busy;
  assign OOR        = oor;
  assign MISALIGN   = mis;
  assign ERR_STICKY = err_q;
  assign test_value = tv_word[DATA_WIDTH/2-1:0];

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - randomized scoreboard bench for data_memory_sized against a byte-array model
module tb_data_memory_sized;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A;
  logic        WE;
  logic [1:0]  SIZE;
  logic        UNS;
  logic [31:0] WD;
  logic        CLR;
  logic [31:0] RD;
  logic        BUSY;
  logic        OOR;
  logic        MISALIGN;
  logic        ERR_STICKY;
  logic [15:0] test_value;

  always #5 CLK = ~CLK;

  data_memory_sized dut (
    .CLK(CLK), .RST(RST), .A(A), .WE(WE), .SIZE(SIZE), .UNS(UNS), .WD(WD), .CLR(CLR),
    .RD(RD), .BUSY(BUSY), .OOR(OOR), .MISALIGN(MISALIGN), .ERR_STICKY(ERR_STICKY),
    .test_value(test_value)
  );

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        busy;
    logic        oor;
    logic        mis;
    logic        err;
    logic [15:0] tv;
    bit          chk_tv;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  byte unsigned mb[1024];
  int busy_left;
  int scrub_w;
  bit err_m;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  initial begin
    forever begin
      exp_t e;
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.nm, ".rd"},   RD,         e.rd);
        check({e.nm, ".busy"}, BUSY,       e.busy);
        check({e.nm, ".oor"},  OOR,        e.oor);
        check({e.nm, ".mis"},  MISALIGN,   e.mis);
        check({e.nm, ".err"},  ERR_STICKY, e.err);
        if (e.chk_tv) check({e.nm, ".tv"}, test_value, e.tv);
      end
    end
  end

  function automatic bit m_mis(logic [31:0] a, logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] a, logic [1:0] sz, logic uns);
    int n = nbytes(sz);
    int base = int'(a) & ~(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(mb[base + i]) << (8 * i);
    if (n < 4 && !uns && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic cycle(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic clr, input string nm,
                       input bit fix, input logic [31:0] fix_rd);
    exp_t e;
    bit oor, mis, busy;
    WE = we; SIZE = sz; UNS = uns; A = a; WD = wd; CLR = clr;
    oor  = (a >> 2) >= 256;
    mis  = m_mis(a, sz);
    busy = (busy_left > 0) || !RST;
    e.nm = nm; e.busy = busy; e.oor = oor; e.mis = mis; e.err = err_m;
    e.rd = (busy || oor || mis) ? 32'd0 : m_load(a, sz, uns);
    if (fix) e.rd = fix_rd;
    e.tv = {mb[1], mb[0]};
    e.chk_tv = !busy;
    exp_q.push_back(e);
    @(posedge CLK);
    if (!RST) begin
      busy_left = 256; scrub_w = 0; err_m = 0;
    end else begin
      if (busy_left > 0) begin
        for (int k = 0; k < 4; k++) mb[4*scrub_w + k] = 8'd0;
        scrub_w++;
        busy_left--;
      end else begin
        if (we && !oor && !mis) begin
          int n = nbytes(sz);
          int base = int'(a) & ~(n - 1);
          for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
        end
        if (we && (oor || mis)) err_m = 1;
        if (clr) begin busy_left = 256; scrub_w = 0; end
      end
      if (clr) err_m = 0;
    end
    #1;
  endtask

  task automatic idle_load(input string nm);
    cycle(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
          32'd0, 1'b0, nm, 1'b0, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mb[i] = 8'd0;
    busy_left = 256; scrub_w = 0; err_m = 0;
    RST = 1'b0; A = '0; WE = 1'b0; SIZE = 2'd0; UNS = 1'b0; WD = '0; CLR = 1'b0;
    @(posedge CLK); #1;
    repeat (3) cycle(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "reset", 1'b0, 32'd0);
    RST = 1'b1;
    repeat (258) idle_load("scrub0");

    cycle(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, 1'b0, "st_word", 1'b0, 32'd0);
    cycle(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, "ld_byte_s", 1'b1, 32'hFFFFFF88);
    cycle(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, "ld_byte_u", 1'b1, 32'h00000088);
    cycle(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b0, "st_half", 1'b0, 32'd0);
    cycle(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, "ld_word", 1'b1, 32'h1234AABB);
    cycle(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, "ld_half_s", 1'b1, 32'hFFFFAABB);

    cycle(1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, 1'b0, "oor_store", 1'b1, 32'd0);
    cycle(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, "oor_load", 1'b1, 32'd0);
    cycle(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "oor_nowrite", 1'b1, 32'd0);
    cycle(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, "clr", 1'b0, 32'd0);
    repeat (100) idle_load("scrub1");
    RST = 1'b0;
    repeat (2) cycle(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "mid_reset", 1'b0, 32'd0);
    RST = 1'b1;
    repeat (258) idle_load("scrub2");

    cycle(1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D, 1'b0, "st_mis", 1'b0, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    cycle(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, "mis_chk", 1'b1, 32'h00000000);
`else
    cycle(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, "mis_chk", 1'b1, 32'hCAFEF00D);
`endif

    for (int it = 0; it < 1500; it++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      if (r < 70)      a = 32'($urandom_range(0, 63));
      else if (r < 90) a = 32'($urandom_range(0, 1023));
      else             a = $urandom;
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
            $urandom, 1'($urandom_range(0, 199) == 0), "rand", 1'b0, 32'd0);
    end

    WE = 1'b0; CLR = 1'b0;
    @(negedge CLK); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
